// File: rtl/led_scan_decoder.sv
// led_scan_decoder: receive-side monitor for a scanned 4-digit seven-segment bus.
// Resynchronizes the bus, waits for each digit to settle, decodes the segments
// back to BCD and publishes a complete frame with a one-cycle valid pulse.
module led_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [6:0]  i_led_segment,
    input  logic [3:0]  i_led_digit,
    output logic [15:0] o_digits,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_timeout
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_SEL, SETTLE, HOLD} state_t;

    state_t           state, state_nxt;
    logic [6:0]       seg_s1, seg_s2, seg_prev;
    logic [3:0]       dig_s1, dig_s2, dig_prev;
    logic [SW-1:0]    cnt;
    logic [TW-1:0]    tcnt;
    logic [3:0][3:0]  slots;
    logic [3:0]       seen;
    logic             err_acc;
    logic             sel_ok, changed, capture, cnt_clr, cnt_inc, inv;
    logic [1:0]       idx;
    logic [3:0]       nib;

    // Two-flop synchronizer plus a one-cycle history for change detection; idle is all ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seg_s1   <= '1;
            seg_s2   <= '1;
            seg_prev <= '1;
            dig_s1   <= '1;
            dig_s2   <= '1;
            dig_prev <= '1;
        end else begin
            seg_s1   <= i_led_segment;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            dig_s1   <= i_led_digit;
            dig_s2   <= dig_s1;
            dig_prev <= dig_s2;
        end
    end

    assign changed = (seg_s2 != seg_prev) || (dig_s2 != dig_prev);

    // One-cold select to digit index; anything else is treated as idle.
    always_comb begin
        sel_ok = 1'b1;
        idx    = 2'd0;
        case (dig_s2)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: sel_ok = 1'b0;
        endcase
    end

    // Segment pattern (g..a, active-low) back to BCD; blank is F, garbage is E.
    always_comb begin
        inv = 1'b0;
        nib = 4'hE;
        case (seg_s2)
            7'b1000000: nib = 4'd0;
            7'b1111001: nib = 4'd1;
            7'b0100100: nib = 4'd2;
            7'b0110000: nib = 4'd3;
            7'b0011001: nib = 4'd4;
            7'b0010010: nib = 4'd5;
            7'b0000011: nib = 4'd6;
            7'b1111000: nib = 4'd7;
            7'b0000000: nib = 4'd8;
            7'b0010000: nib = 4'd9;
            7'b1111111: nib = 4'hF;
            default:    inv = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= WAIT_SEL;
        else       state <= state_nxt;
    end

    // Next state and settle-counter control; capture fires on the last stable cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            WAIT_SEL: begin
                if (sel_ok) begin
                    state_nxt = SETTLE;
                    cnt_clr   = 1'b1;
                end
            end
            SETTLE: begin
                if (!sel_ok) begin
                    state_nxt = WAIT_SEL;
                end else if (changed) begin
                    cnt_clr = 1'b1;
                end else if (cnt == SETTLE_LAST) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                // Only a new digit re-arms settling; segment churn on the same digit is ignored.
                if (!sel_ok) begin
                    state_nxt = WAIT_SEL;
                end else if (dig_s2 != dig_prev) begin
                    state_nxt = SETTLE;
                    cnt_clr   = 1'b1;
                end
            end
            default: state_nxt = WAIT_SEL;
        endcase
    end

    // Saturating settle counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                             cnt <= '0;
        else if (cnt_clr)                      cnt <= '0;
        else if (cnt_inc && cnt != SETTLE_MAX) cnt <= cnt + 1'b1;
    end

    // Frame assembly, publish one cycle after the frame fills, and timeout tracking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slots     <= '0;
            seen      <= '0;
            err_acc   <= 1'b0;
            tcnt      <= '0;
            o_digits  <= '0;
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (seen == 4'hF) begin
                o_digits <= slots;
                o_valid  <= 1'b1;
                o_err    <= err_acc;
                seen     <= '0;
                err_acc  <= 1'b0;
            end
            if (capture) begin
                slots[idx] <= nib;
                seen[idx]  <= 1'b1;
                err_acc    <= err_acc | inv;
                tcnt       <= '0;
                o_timeout  <= 1'b0;
            end else if (tcnt != TOUT_MAX) begin
                tcnt <= tcnt + 1'b1;
                if (tcnt == TOUT_LAST) begin
                    o_timeout <= 1'b1;
                    seen      <= '0;
                    err_acc   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder with SETTLE_CYCLES=4, TIMEOUT_CYCLES=100.
module tb_led_scan_decoder;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [6:0]  i_led_segment = 7'h7F;
    logic [3:0]  i_led_digit = 4'hF;
    logic [15:0] o_digits;
    logic        o_valid, o_err, o_timeout;

    int checks = 0, failures = 0;
    int vcnt = 0, dbl = 0, err_nv = 0;
    logic [15:0] last_d = '0;
    logic        last_e = 1'b0, prev_v = 1'b0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
        S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000011,
        S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000, SBL = 7'b1111111,
        SBAD = 7'b1010101;
    localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111,
        DIDLE = 4'b1111;

    led_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_led_segment(i_led_segment),
        .i_led_digit(i_led_digit), .o_digits(o_digits), .o_valid(o_valid),
        .o_err(o_err), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Record every valid pulse away from the active edge.
    always @(negedge i_clk) begin
        if (o_valid) begin
            vcnt++;
            last_d = o_digits;
            last_e = o_err;
            if (prev_v) dbl++;
        end else if (o_err) begin
            err_nv++;
        end
        prev_v = o_valid;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic scan(input logic [3:0] d, input logic [6:0] s, input int n);
        i_led_digit = d;
        i_led_segment = s;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic frame(input logic [6:0] s0, s1, s2, s3);
        scan(D0, s0, 10);
        scan(D1, s1, 10);
        scan(D2, s2, 10);
        scan(D3, s3, 10);
        scan(DIDLE, SBL, 4);
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_digits", o_digits, 16'h0000);
        chk("rst_valid", o_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_timeout", o_timeout, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Normal scan: 4,3,2,1 on digits 0..3
        vcnt = 0;
        frame(S4, S3, S2, S1);
        chk("norm_cnt", vcnt, 1);
        chk("norm_digits", last_d, 16'h1234);
        chk("norm_err", last_e, 0);

        // Short dwell on digit1 must not capture
        vcnt = 0;
        scan(D0, S7, 10);
        scan(D1, S1, 3);
        scan(D2, S9, 10);
        scan(D3, S6, 10);
        scan(DIDLE, SBL, 4);
        chk("short_none", vcnt, 0);
        scan(D1, S8, 6);
        scan(DIDLE, SBL, 4);
        chk("short_cnt", vcnt, 1);
        chk("short_digits", last_d, 16'h6987);

        // Invalid pattern on digit2, then a clean frame
        vcnt = 0;
        frame(S0, S0, SBAD, S0);
        chk("inv_cnt", vcnt, 1);
        chk("inv_digits", last_d, 16'h0E00);
        chk("inv_err", last_e, 1);
        frame(S1, S1, S1, S1);
        chk("clean_cnt", vcnt, 2);
        chk("clean_digits", last_d, 16'h1111);
        chk("clean_err", last_e, 0);

        // Blank digit3
        vcnt = 0;
        frame(S5, S5, S5, SBL);
        chk("blank_digits", last_d, 16'hF555);
        chk("blank_err", last_e, 0);

        // Timeout abandons a partial frame
        vcnt = 0;
        scan(D0, S6, 10);
        scan(D1, S7, 10);
        scan(DIDLE, SBL, 120);
        chk("to_flag", o_timeout, 1);
        chk("to_novalid", vcnt, 0);
        scan(D2, S8, 10);
        chk("to_clear", o_timeout, 0);
        scan(D3, S9, 10);
        scan(DIDLE, SBL, 4);
        chk("to_seen_cleared", vcnt, 0);
        scan(D0, S6, 10);
        scan(D1, S7, 10);
        scan(DIDLE, SBL, 4);
        chk("to_cnt", vcnt, 1);
        chk("to_digits", last_d, 16'h9876);

        // Reset mid-frame discards the partial frame
        vcnt = 0;
        scan(D0, S3, 10);
        scan(D1, S3, 10);
        scan(D2, S3, 10);
        i_rst = 1'b1;
        #1;
        chk("mrst_digits", o_digits, 16'h0000);
        chk("mrst_valid", o_valid, 0);
        chk("mrst_timeout", o_timeout, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        scan(D3, S3, 10);
        scan(DIDLE, SBL, 4);
        chk("mrst_partial", vcnt, 0);
        frame(S3, S3, S3, S3);
        chk("mrst_cnt", vcnt, 1);
        chk("mrst_digits2", last_d, 16'h3333);

        chk("valid_double", dbl, 0);
        chk("err_unqualified", err_nv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
